// File: rtl/sram_arbiter.sv
// Merges the core's instruction and data SRAM ports onto one variable-latency
// memory bus, one outstanding transaction at a time, stalling the pipeline until done.
module sram_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        pend_inst_q, pend_inst_d;
    logic        pend_data_q, pend_data_d;
    logic        sel_data_q, sel_data_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [3:0]  data_wen_q, data_wen_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    // The instruction side is read-only; its write fields are deliberately dropped.
    logic unused_inst_wr;
    assign unused_inst_wr = ^{inst_sram_wen, inst_sram_wdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pend_inst_q  <= 1'b0;
            pend_data_q  <= 1'b0;
            sel_data_q   <= 1'b0;
            inst_addr_q  <= 32'd0;
            data_addr_q  <= 32'd0;
            data_wen_q   <= 4'd0;
            data_wdata_q <= 32'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pend_inst_q  <= pend_inst_d;
            pend_data_q  <= pend_data_d;
            sel_data_q   <= sel_data_d;
            inst_addr_q  <= inst_addr_d;
            data_addr_q  <= data_addr_d;
            data_wen_q   <= data_wen_d;
            data_wdata_q <= data_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_inst_d  = pend_inst_q;
        pend_data_d  = pend_data_q;
        sel_data_d   = sel_data_q;
        inst_addr_d  = inst_addr_q;
        data_addr_d  = data_addr_q;
        data_wen_d   = data_wen_q;
        data_wdata_d = data_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (inst_sram_en || data_sram_en) begin
                    pend_inst_d  = inst_sram_en;
                    pend_data_d  = data_sram_en;
                    inst_addr_d  = inst_sram_addr;
                    data_addr_d  = data_sram_addr;
                    data_wen_d   = data_sram_wen;
                    data_wdata_d = data_sram_wdata;
                    sel_data_d   = data_sram_en && (DATA_FIRST || !inst_sram_en);
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion hands straight over to the other pending side, if any.
                if (mem_rvalid) begin
                    if (sel_data_q) begin
                        if (data_wen_q == 4'd0) begin
                            data_rdata_d = mem_rdata;
                        end
                        pend_data_d = 1'b0;
                        if (pend_inst_q) begin
                            sel_data_d = 1'b0;
                            state_d    = S_REQ;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        inst_rdata_d = mem_rdata;
                        pend_inst_d  = 1'b0;
                        if (pend_data_q) begin
                            sel_data_d = 1'b1;
                            state_d    = S_REQ;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic req_data;
    assign req_data = (state_q == S_REQ) && sel_data_q;

    assign mem_req   = (state_q == S_REQ);
    assign mem_wr    = req_data && (data_wen_q != 4'd0);
    assign mem_wstrb = req_data ? data_wen_q : 4'd0;
    assign mem_addr  = mem_req ? (sel_data_q ? data_addr_q : inst_addr_q) : 32'd0;
    assign mem_wdata = req_data ? data_wdata_q : 32'd0;

    // Gated by reset so held enables cannot raise a stall while reset is asserted.
    assign stallreq = rst && (((state_q == S_IDLE) && (inst_sram_en || data_sram_en))
                              || (state_q == S_REQ) || (state_q == S_WAIT));

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sits between `mycpu_core` and a single external memory port, merging the core's instruction-SRAM and data-SRAM interfaces onto one request/response bus with variable latency. It holds at most one outstanding transaction, serializes simultaneous instruction and data requests, and raises `stallreq` so the pipeline freezes until every request presented in a cycle has completed. Read data is returned on registered `*_sram_rdata` outputs.

## Interface
- `DATA_FIRST`, default 1: when both requests are pending, 1 services data before instruction; 0 services instruction first.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `inst_sram_en` input 1: instruction request; held stable with address while `stallreq`=1.
- `inst_sram_wen` input 4: ignored (instruction side is read-only).
- `inst_sram_addr` input 32: instruction byte address.
- `inst_sram_wdata` input 32: ignored.
- `inst_sram_rdata` output 32: registered instruction word.
- `data_sram_en` input 1: data request.
- `data_sram_wen` input 4: byte strobes; 0 = read, nonzero = write.
- `data_sram_addr` input 32: data byte address.
- `data_sram_wdata` input 32: write data.
- `data_sram_rdata` output 32: registered load data.
- `stallreq` output 1: pipeline stall request to CTRL.
- `mem_req` output 1: request valid toward memory.
- `mem_wr` output 1: 1 = write.
- `mem_wstrb` output 4: byte strobes (0 for reads).
- `mem_addr` output 32: address.
- `mem_wdata` output 32: write data.
- `mem_ready` input 1: memory accepts request this cycle (handshake when `mem_req`&`mem_ready`).
- `mem_rvalid` input 1: one-cycle response pulse; one per accepted request (reads and writes).
- `mem_rdata` input 32: read data, valid with `mem_rvalid`.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: if `inst_sram_en`|`data_sram_en`, latch pending flags, addresses, `data_sram_wen`, `data_sram_wdata`; select first transaction per `DATA_FIRST`; go REQ. Otherwise stay.
- REQ: `mem_req`=1 with selected transaction's fields. On `mem_ready`=1 go WAIT; else hold all `mem_*` stable.
- WAIT: `mem_req`=0. On `mem_rvalid`: if read, capture `mem_rdata` into matching rdata register; clear that pending flag; if other flag still set go REQ with it, else go DONE.
- DONE: one cycle, `stallreq`=0, then IDLE. Request inputs in DONE are not sampled (they belong to the completed instruction).
- `stallreq` = (IDLE & (`inst_sram_en`|`data_sram_en`)) | REQ | WAIT. Combinational from enables in IDLE only.
- Write transactions leave `data_sram_rdata` unchanged. `inst_sram_rdata`/`data_sram_rdata` hold value until overwritten by a later read.
- `mem_rvalid` outside WAIT is ignored. `mem_ready` outside REQ is ignored.
- Addresses passed unmodified (no alignment, no translation).

## Timing
- Reset (`rst`=0, async): state IDLE, pending flags 0, `mem_req`=0, `mem_wr`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, both rdata=0, `stallreq`=0 (no enables can stall while in reset). Reset mid-transaction abandons it; `mem_req` drops immediately.
- Single read, `mem_ready` same cycle, response 1 cycle after accept: T0 IDLE (stall), T1 REQ accepted, T2 WAIT rvalid, T3 DONE (rdata valid, stall low), T4 IDLE. Stall cycles = 3.
- Each extra `mem_ready`-low or rvalid-delay cycle adds one stall cycle.
- Dual request: second transaction's REQ immediately follows first's WAIT response; no IDLE between.
- `mem_rvalid` never arrives in the acceptance cycle; earliest is the cycle after.

## Test plan
- Inst read only, addr 0xBFC00000, `mem_ready`=1, `mem_rdata`=0x3C010001 one cycle after accept -> `mem_req` high exactly 1 cycle, `stallreq` high 3 cycles, `inst_sram_rdata`=0x3C010001 in DONE.
- Simultaneous inst read 0xBFC00004 and data read 0x80001000, `DATA_FIRST`=1 -> `mem_addr` sequence 0x80001000 then 0xBFC00004; `data_sram_rdata`/`inst_sram_rdata` get respective words; stall 5 cycles.
- Data write wen=4'b0011, addr 0x80002000, wdata 0xDEADBEEF, `mem_ready` low 3 cycles -> `mem_wr`=1, `mem_wstrb`=0011, fields stable all 4 REQ cycles; `data_sram_rdata` unchanged.
- Response delayed 5 cycles with spurious `mem_rvalid` pulse during REQ -> spurious pulse ignored; completion only on WAIT pulse.
- `rst` asserted during WAIT -> all outputs to reset values within the same cycle; after release, new inst request completes normally.
- `DATA_FIRST`=0 with dual request -> instruction address issued first.
